// File: rtl/arb_mux.sv
// arb_mux: steered or round-robin N:1 valid/ready mux into a single-entry output register
module arb_mux #(
  parameter int busSize = 8,
  parameter int nIn     = 4,
  parameter int selW    = $clog2(nIn)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [nIn*busSize-1:0] in_data,
  input  logic [nIn-1:0]         in_valid,
  output logic [nIn-1:0]         in_ready,
  input  logic                   mode,
  input  logic [selW-1:0]        sel,
  output logic [busSize-1:0]     out_data,
  output logic [selW-1:0]        out_chan,
  output logic                   out_valid,
  input  logic                   out_ready
);
  logic [busSize-1:0] out_data_q, out_data_d;
  logic [selW-1:0]    out_chan_q, out_chan_d;
  logic               out_valid_q, out_valid_d;
  logic [selW-1:0]    last_q, last_d;
  logic [selW-1:0]    rr_g, rr_idx, g;
  logic               rr_hit, hit, load, xfer;
  always_comb begin
    rr_g   = '0;
    rr_idx = '0;
    rr_hit = 1'b0;
    // scan from the farthest offset down so the nearest valid channel after last_q wins
    for (int i = nIn; i >= 1; i--) begin
      rr_idx = selW'((int'(last_q) + i) % nIn);
      if (in_valid[rr_idx]) begin
        rr_g   = rr_idx;
        rr_hit = 1'b1;
      end
    end
  end
  assign load     = ~out_valid_q | out_ready;
  assign g        = mode ? rr_g : sel;
  assign hit      = mode ? rr_hit : (int'(sel) < nIn);
  assign in_ready = (rst_n && hit && load) ? nIn'(1) << g : '0;
  assign xfer     = |(in_ready & in_valid);
  always_comb begin
    out_data_d  = xfer ? in_data[int'(g)*busSize +: busSize] : out_data_q;
    out_chan_d  = xfer ? g : out_chan_q;
    out_valid_d = xfer ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
    last_d      = (xfer && mode) ? g : last_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      last_q      <= selW'(nIn - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
    end
  end
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;
endmodule
